// File: rtl/booth_operand_sequencer_pkg.sv
// Shared definitions for the Booth operand sequencer: default sizing and FSM states.
package booth_operand_sequencer_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 32;

    // Sequencer states; encodings are fixed so waveforms match across tools.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/booth_operand_sequencer_fifo.sv
// Synchronous operand FIFO: DEPTH entries, no bypass in either direction.
// A push is refused whenever the FIFO is full, even if a pop happens the same cycle.
module booth_seq_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care after reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/booth_operand_sequencer.sv
// Booth operand sequencer: buffers signed operand pairs, drives the radix-4 multiplier's
// level go/over handshake, and returns each product (or a timeout marker) through a
// single-entry valid/ready result register.
module booth_operand_sequencer
    import booth_operand_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [WIDTH-1:0]       op_mplier,
    input  logic [WIDTH-1:0]       op_mpcand,
    output logic [WIDTH-1:0]       mplier,
    output logic [WIDTH-1:0]       mpcand,
    output logic                   go,
    input  logic [2*WIDTH-1:0]     prod,
    input  logic                   over,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*WIDTH-1:0]     res_prod,
    output logic                   res_err,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] head;
    logic               do_issue;
    logic               do_done;
    logic               do_timeout;
    logic               do_clear;

    assign op_ready = ~fifo_full;

    booth_seq_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (op_valid & op_ready),
        .pop     (do_issue),
        .wr_data ({op_mplier, op_mpcand}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Next-state and control strobes; over takes priority over a same-cycle timeout.
    always_comb begin
        state_d    = state_q;
        do_issue   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        do_clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !res_valid) begin
                    do_issue = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (over) begin
                    do_done = 1'b1;
                    state_d = RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                if (!over) begin
                    do_clear = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch and go; operands stay frozen for the whole time go is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            mplier <= '0;
            mpcand <= '0;
            go     <= 1'b0;
        end else if (do_issue) begin
            mplier <= head[2*WIDTH-1:WIDTH];
            mpcand <= head[WIDTH-1:0];
            go     <= 1'b1;
        end else if (do_done || do_timeout) begin
            go <= 1'b0;
        end
    end

    // Cycles spent in ISSUE, used to bound the wait for over.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (do_issue || do_clear) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Single-entry result register; holds its contents until downstream takes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_prod  <= '0;
            res_err   <= 1'b0;
        end else if (do_done) begin
            res_valid <= 1'b1;
            res_prod  <= prod;
            res_err   <= 1'b0;
        end else if (do_timeout) begin
            res_valid <= 1'b1;
            res_prod  <= '0;
            res_err   <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
